// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline hazard signal bundle between datapath and hazard_controller
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       IF_ID_rs;
  logic [2:0]       IF_ID_rt;
  logic             IF_ID_UsesRt;
  logic             ID_EXE_MemRd;
  logic [2:0]       ID_EXE_rd;
  logic             BranchTaken;
  logic             MemReq;
  logic             MemAck;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EXE_Write;
  logic             EXE_MEM_Write;
  logic             IF_ID_Flush;
  logic             ID_EXE_Flush;
  logic             ID_EXE_Bubble;
  logic             MEM_WB_Bubble;
  logic             MemTimeout;
  logic [CNT_W-1:0] LoadStallCnt;
  logic [CNT_W-1:0] FlushCnt;
  logic [CNT_W-1:0] WaitCnt;

  modport master (
    output IF_ID_rs, IF_ID_rt, IF_ID_UsesRt, ID_EXE_MemRd, ID_EXE_rd,
           BranchTaken, MemReq, MemAck,
    input  PCWrite, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write,
           IF_ID_Flush, ID_EXE_Flush, ID_EXE_Bubble, MEM_WB_Bubble,
           MemTimeout, LoadStallCnt, FlushCnt, WaitCnt
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, IF_ID_UsesRt, ID_EXE_MemRd, ID_EXE_rd,
           BranchTaken, MemReq, MemAck,
    output PCWrite, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write,
           IF_ID_Flush, ID_EXE_Flush, ID_EXE_Bubble, MEM_WB_Bubble,
           MemTimeout, LoadStallCnt, FlushCnt, WaitCnt
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use stall, branch flush and memory-wait freeze sequencer with watchdog
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_controller_if.slave hz
);
  localparam int WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              load_use;
  logic              resolve;
  logic              freeze;
  logic              do_flush;
  logic              do_stall;

  assign load_use = hz.ID_EXE_MemRd && (hz.ID_EXE_rd != 3'd0) &&
                    ((hz.ID_EXE_rd == hz.IF_ID_rs) ||
                     (hz.IF_ID_UsesRt && (hz.ID_EXE_rd == hz.IF_ID_rt)));

  always_comb begin
    state_d          = state_q;
    wcnt_d           = wcnt_q;
    resolve          = 1'b0;
    freeze           = 1'b0;
    hz.PCWrite       = 1'b1;
    hz.IF_ID_Write   = 1'b1;
    hz.ID_EXE_Write  = 1'b1;
    hz.EXE_MEM_Write = 1'b1;
    hz.IF_ID_Flush   = 1'b0;
    hz.ID_EXE_Flush  = 1'b0;
    hz.ID_EXE_Bubble = 1'b0;
    hz.MEM_WB_Bubble = 1'b0;
    hz.MemTimeout    = 1'b0;

    case (state_q)
      S_RUN: begin
        if (hz.MemReq && !hz.MemAck) begin
          freeze  = 1'b1;
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      S_WAIT: begin
        if (!hz.MemAck) begin
          freeze = 1'b1;
          if (wcnt_q == WCNT_W'(MAX_WAIT)) begin
            state_d = S_ERROR;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else begin
          // Upstream inputs were held by the freeze, so the stalled decision resolves now.
          resolve = 1'b1;
          state_d = S_RUN;
        end
      end
      S_ERROR: begin
        hz.PCWrite       = 1'b0;
        hz.IF_ID_Write   = 1'b0;
        hz.ID_EXE_Write  = 1'b0;
        hz.EXE_MEM_Write = 1'b0;
        hz.ID_EXE_Bubble = 1'b1;
        hz.MEM_WB_Bubble = 1'b1;
        hz.MemTimeout    = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    do_flush = resolve && hz.BranchTaken;
    do_stall = resolve && !hz.BranchTaken && load_use;

    if (freeze) begin
      hz.PCWrite       = 1'b0;
      hz.IF_ID_Write   = 1'b0;
      hz.ID_EXE_Write  = 1'b0;
      hz.EXE_MEM_Write = 1'b0;
      hz.MEM_WB_Bubble = 1'b1;
    end
    if (do_flush) begin
      hz.IF_ID_Flush  = 1'b1;
      hz.ID_EXE_Flush = 1'b1;
    end
    if (do_stall) begin
      hz.PCWrite       = 1'b0;
      hz.IF_ID_Write   = 1'b0;
      hz.ID_EXE_Bubble = 1'b1;
    end

    if (!rst_n) begin
      hz.PCWrite       = 1'b0;
      hz.IF_ID_Write   = 1'b0;
      hz.ID_EXE_Write  = 1'b0;
      hz.EXE_MEM_Write = 1'b0;
      hz.IF_ID_Flush   = 1'b1;
      hz.ID_EXE_Flush  = 1'b1;
      hz.ID_EXE_Bubble = 1'b1;
      hz.MEM_WB_Bubble = 1'b1;
      hz.MemTimeout    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] ls_cnt_q, ls_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0] wt_cnt_q, wt_cnt_d;

  // Saturating counters: stop at all-ones rather than wrapping.
  always_comb begin
    ls_cnt_d = ls_cnt_q;
    fl_cnt_d = fl_cnt_q;
    wt_cnt_d = wt_cnt_q;
    if (do_stall && !(&ls_cnt_q)) ls_cnt_d = ls_cnt_q + 1'b1;
    if (do_flush && !(&fl_cnt_q)) fl_cnt_d = fl_cnt_q + 1'b1;
    if (freeze   && !(&wt_cnt_q)) wt_cnt_d = wt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ls_cnt_q <= '0;
      fl_cnt_q <= '0;
      wt_cnt_q <= '0;
    end else begin
      ls_cnt_q <= ls_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      wt_cnt_q <= wt_cnt_d;
    end
  end

  assign hz.LoadStallCnt = ls_cnt_q;
  assign hz.FlushCnt     = fl_cnt_q;
  assign hz.WaitCnt      = wt_cnt_q;
`else
  assign hz.LoadStallCnt = '0;
  assign hz.FlushCnt     = '0;
  assign hz.WaitCnt      = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed and randomized checks of hazard_controller against a behavioural model
module tb_hazard_controller;
  localparam int MW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(CW)) hz ();

  hazard_controller #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int total  = 0;
  int passed = 0;

  bit m_known = 1'b0;
  bit m_wait  = 1'b0;
  bit m_err   = 1'b0;
  int m_waited = 0;
  int m_ls = 0, m_fl = 0, m_wc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // One clock cycle: drive at the falling edge, check the Mealy outputs, then advance the model.
  task automatic cyc(input string tag, input bit r, input bit [2:0] rs, input bit [2:0] rt,
                     input bit uses, input bit memrd, input bit [2:0] rd,
                     input bit br, input bit mreq, input bit mack);
    bit lu, frz;
    logic [8:0] exp_o, obs_o;
    @(negedge clk);
    rst_n           = r;
    hz.IF_ID_rs     = rs;
    hz.IF_ID_rt     = rt;
    hz.IF_ID_UsesRt = uses;
    hz.ID_EXE_MemRd = memrd;
    hz.ID_EXE_rd    = rd;
    hz.BranchTaken  = br;
    hz.MemReq       = mreq;
    hz.MemAck       = mack;
    #1;
    lu  = memrd && (rd != 0) && ((rd == rs) || (uses && (rd == rt)));
    frz = m_wait ? !mack : (mreq && !mack);
    // {PCWrite, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write, IF_ID_Flush, ID_EXE_Flush, ID_EXE_Bubble, MEM_WB_Bubble, MemTimeout}
    if (!r)          exp_o = 9'b0000_11_11_0;
    else if (m_err)  exp_o = 9'b0000_00_11_1;
    else if (frz)    exp_o = 9'b0000_00_01_0;
    else if (br)     exp_o = 9'b1111_11_00_0;
    else if (lu)     exp_o = 9'b0011_00_10_0;
    else             exp_o = 9'b1111_00_00_0;
    obs_o = {hz.PCWrite, hz.IF_ID_Write, hz.ID_EXE_Write, hz.EXE_MEM_Write,
             hz.IF_ID_Flush, hz.ID_EXE_Flush, hz.ID_EXE_Bubble, hz.MEM_WB_Bubble, hz.MemTimeout};
    check({tag, ".ctl"}, 32'(obs_o), 32'(exp_o));
    if (m_known) begin
      check({tag, ".ls_cnt"}, 32'(hz.LoadStallCnt), PERF ? m_ls : 0);
      check({tag, ".fl_cnt"}, 32'(hz.FlushCnt),     PERF ? m_fl : 0);
      check({tag, ".wt_cnt"}, 32'(hz.WaitCnt),      PERF ? m_wc : 0);
    end
    if (!r) begin
      m_known = 1'b1; m_wait = 1'b0; m_err = 1'b0; m_waited = 0;
      m_ls = 0; m_fl = 0; m_wc = 0;
    end else if (!m_err) begin
      if (frz) begin
        m_wc = sat_inc(m_wc);
        if (!m_wait) begin
          m_wait = 1'b1; m_waited = 1;
        end else if (m_waited == MW) begin
          m_err = 1'b1; m_wait = 1'b0;
        end else begin
          m_waited++;
        end
      end else begin
        m_wait = 1'b0;
        if (br)      m_fl = sat_inc(m_fl);
        else if (lu) m_ls = sat_inc(m_ls);
      end
    end
  endtask

  initial begin
    bit [2:0] rs, rt, rd;
    rst_n = 1'b0;
    hz.IF_ID_rs = '0; hz.IF_ID_rt = '0; hz.IF_ID_UsesRt = 1'b0; hz.ID_EXE_MemRd = 1'b0;
    hz.ID_EXE_rd = '0; hz.BranchTaken = 1'b0; hz.MemReq = 1'b0; hz.MemAck = 1'b0;

    cyc("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle",   1, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc("lu_rs",       1, 3, 5, 0, 1, 3, 0, 0, 0);
    cyc("lu_after",    1, 3, 5, 0, 0, 0, 0, 0, 0);
    cyc("lu_r0",       1, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc("lu_rt_nouse", 1, 1, 4, 0, 1, 4, 0, 0, 0);
    cyc("lu_rt_use",   1, 1, 4, 1, 1, 4, 0, 0, 0);

    cyc("br_lu",       1, 3, 0, 0, 1, 3, 1, 0, 0);
    cyc("br_only",     1, 2, 0, 0, 0, 0, 1, 0, 0);

    cyc("mw_enter",    1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_w1",       1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_w2",       1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_ack",      1, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("mw_after",    1, 0, 0, 0, 0, 0, 0, 0, 0);
    if (PERF) check("waitcnt_3", 32'(hz.WaitCnt), 3);

    cyc("zero_wait",   1, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("zw_after",    1, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc("pb_enter",    1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("pb_w1",       1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("pb_ack",      1, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc("pb_after",    1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++) cyc("timeout", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("err_ack",     1, 3, 0, 0, 1, 3, 1, 1, 1);
    check("timeout_sticky", 32'(hz.MemTimeout), 1);
    cyc("err_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_timeout", 32'(hz.MemTimeout), 0);
    check("post_rst_waitcnt", 32'(hz.WaitCnt), 0);

    for (int i = 0; i < 1500; i++) begin
      rs = 3'($urandom_range(0, 7));
      rt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       rd = rs;
        1:       rd = rt;
        default: rd = 3'($urandom_range(0, 7));
      endcase
      cyc("rand", $urandom_range(0, 59) != 0, rs, rt, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), rd, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
